// File: rtl/btn_pkg.sv
// Shared constants, types and helpers for the push-button scan controller.
package btn_pkg;

  localparam int N_BTN_DEF        = 5;
  localparam int TICK_DIV_DEF     = 1000;
  localparam int STABLE_SCANS_DEF = 100;
  localparam int FIFO_DEPTH_DEF   = 4;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDW_DEF = idw(N_BTN_DEF);

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic               rise;
  } btn_evt_t;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous show-ahead FIFO of button events; the head entry is always on dout.
module btn_evt_fifo
  import btn_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter type T     = btn_evt_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign dout  = mem_r[rptr_r];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r] <= din;
        wptr_r        <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Round-robin push-button debouncer: one shared scan slot walks the buttons,
// stability counters decide the debounced level, qualified edges are queued for the CPU.
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_SCANS = STABLE_SCANS_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        btn_raw,
  input  logic [N_BTN-1:0]        cfg_rise_en,
  input  logic [N_BTN-1:0]        cfg_fall_en,
  output logic [N_BTN-1:0]        btn_state,
  output logic                    evt_valid,
  output logic [idw(N_BTN)-1:0]   evt_id,
  output logic                    evt_rise,
  input  logic                    evt_ready,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int IDW = idw(N_BTN);
  localparam int PW  = $clog2(TICK_DIV);
  localparam int CW  = $clog2(STABLE_SCANS + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           rise;
  } evt_t;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] state_r;
  logic [PW-1:0]    pre_r;
  logic [IDW-1:0]   ptr_r;
  logic [CW-1:0]    cnt_r [N_BTN];
  logic             overflow_r;

  logic             slot_tick_s;
  logic             sel_sync_s;
  logic             sel_state_s;
  logic [CW-1:0]    sel_cnt_s;
  logic             toggle_s;
  logic             new_s;
  logic             qual_s;
  logic             pop_s;
  logic             fifo_push_s;
  logic             full_s;
  logic             empty_s;
  evt_t             push_evt_s;
  evt_t             head_s;

  // Evaluation of the button owning the current scan slot.
  always_comb begin
    slot_tick_s = (pre_r == PW'(TICK_DIV - 1));
    sel_sync_s  = sync2_r[ptr_r];
    sel_state_s = state_r[ptr_r];
    sel_cnt_s   = cnt_r[ptr_r];
    toggle_s    = slot_tick_s & (sel_sync_s != sel_state_s) &
                  (sel_cnt_s == CW'(STABLE_SCANS - 1));
    new_s       = ~sel_state_s;
    if (new_s) begin
      qual_s = toggle_s & cfg_rise_en[ptr_r];
    end else begin
      qual_s = toggle_s & cfg_fall_en[ptr_r];
    end
    push_evt_s.id   = ptr_r;
    push_evt_s.rise = new_s;
    pop_s           = ~empty_s & evt_ready;
    fifo_push_s     = qual_s & (~full_s | pop_s);
  end

  // Two-flop synchronizer on every raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Shared prescaler and round-robin scan pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= '0;
      ptr_r <= '0;
    end else if (slot_tick_s) begin
      pre_r <= '0;
      ptr_r <= (ptr_r == IDW'(N_BTN - 1)) ? IDW'(0) : ptr_r + IDW'(1);
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // Stability counter and debounced level; any matching sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= '0;
      end
      state_r <= '0;
    end else if (slot_tick_s) begin
      if (sel_sync_s == sel_state_s) begin
        cnt_r[ptr_r] <= '0;
      end else if (toggle_s) begin
        cnt_r[ptr_r]   <= '0;
        state_r[ptr_r] <= new_s;
      end else begin
        cnt_r[ptr_r] <= sel_cnt_s + CW'(1);
      end
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (qual_s & full_s & ~pop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .din   (push_evt_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign btn_state = state_r;
  assign evt_valid = ~empty_s;
  assign evt_id    = head_s.id;
  assign evt_rise  = head_s.rise;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus queues expected events, a monitor checks pops.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw, cfg_rise_en, cfg_fall_en, btn_state;
  logic       evt_valid, evt_rise, evt_ready, overflow, ovf_clr;
  logic [1:0] evt_id;

  int         checks = 0;
  int         errors = 0;
  int         ecnt;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN(4), .TICK_DIV(4), .STABLE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .cfg_rise_en(cfg_rise_en),
    .cfg_fall_en(cfg_fall_en), .btn_state(btn_state), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_rise(evt_rise), .evt_ready(evt_ready),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // Edges since reset release; button b is evaluated on edges where ecnt%16 == (4+4b)%16.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Return #1 after the edge on which button b is evaluated.
  task automatic wait_slot(input int b);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (ecnt % 16 == (4 + 4 * b) % 16) return;
    end
    checks++; errors++;
    $display("FAIL wait_slot_timeout: button %0d slot not reached", b);
  endtask

  // Return #1 after the edge just before button b is evaluated.
  task automatic wait_pre(input int b);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (ecnt % 16 == (3 + 4 * b) % 16) return;
    end
    checks++; errors++;
    $display("FAIL wait_pre_timeout: button %0d pre-slot not reached", b);
  endtask

  // Monitor: every accepted pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL evt_unexpected: got id=%0d rise=%0b expected none", evt_id, evt_rise);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_pop", {29'd0, evt_id, evt_rise}, {29'd0, mon_e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_raw = 4'h0; cfg_rise_en = 4'h0; cfg_fall_en = 4'h0;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_state", btn_state, 4'h0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    cfg_rise_en = 4'hF; cfg_fall_en = 4'hF; btn_raw = 4'b0100;
    rst = 1'b0;

    // 1: btn 2 held high toggles on its 3rd mismatching scan
    wait_slot(2); chk("t1_scan1", btn_state, 4'h0);
    wait_slot(2); chk("t1_scan2", btn_state, 4'h0); chk("t1_novalid", evt_valid, 1'b0);
    exp_q.push_back({2'd2, 1'b1});
    wait_slot(2); chk("t1_state", btn_state, 4'b0100); chk("t1_valid", evt_valid, 1'b1);
    evt_ready = 1'b1; @(posedge clk); #1; evt_ready = 1'b0;
    chk("t1_empty", evt_valid, 1'b0);

    // 2: interrupted mismatch runs restart the count
    wait_slot(1); btn_raw[1] = 1'b1;
    wait_slot(1); btn_raw[1] = 1'b0;
    wait_slot(1); btn_raw[1] = 1'b1;
    wait_slot(1);
    wait_slot(1); btn_raw[1] = 1'b0;
    wait_slot(1);
    chk("t2_state", btn_state, 4'b0100);
    chk("t2_valid", evt_valid, 1'b0);

    // 3: fall disabled on btn 0, press/release yields one rise event
    cfg_fall_en = 4'b1110; evt_ready = 1'b1;
    exp_q.push_back({2'd0, 1'b1});
    btn_raw[0] = 1'b1; repeat (64) @(posedge clk); #1;
    btn_raw[0] = 1'b0; repeat (80) @(posedge clk); #1;
    chk("t3_state", btn_state, 4'b0100);
    chk("t3_valid", evt_valid, 1'b0);
    evt_ready = 1'b0; cfg_fall_en = 4'hF;

    // 4: five events with no pops -> four queued, fifth dropped
    wait_slot(3); btn_raw = 4'b1011;
    repeat (3) wait_slot(3);
    chk("t4_state", btn_state, 4'b1011);
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b0}); exp_q.push_back({2'd3, 1'b1});
    btn_raw = 4'b1010;
    repeat (3) wait_slot(0);
    chk("t4_state_drop", btn_state, 4'b1010);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_valid", evt_valid, 1'b1);
    evt_ready = 1'b1; repeat (4) @(posedge clk); #1; evt_ready = 1'b0;
    chk("t4_drained", evt_valid, 1'b0);
    chk("t4_ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 1'b0);

    // 5: full FIFO with a pop in the push cycle -> no drop
    wait_slot(3); btn_raw = 4'b0101;
    repeat (3) wait_slot(3);
    chk("t5_state", btn_state, 4'b0101);
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b0});
    exp_q.push_back({2'd2, 1'b1}); exp_q.push_back({2'd3, 1'b0});
    exp_q.push_back({2'd0, 1'b0});
    btn_raw = 4'b0100;
    wait_slot(0); wait_slot(0); wait_pre(0);
    evt_ready = 1'b1; @(posedge clk); #1; evt_ready = 1'b0;
    chk("t5_state_push", btn_state, 4'b0100);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_valid", evt_valid, 1'b1);
    evt_ready = 1'b1; repeat (4) @(posedge clk); #1; evt_ready = 1'b0;
    chk("t5_drained", evt_valid, 1'b0);

    // 6: reset mid-count with two events queued
    wait_slot(3); btn_raw = 4'b0010;
    repeat (3) wait_slot(3);
    chk("t6_queued", evt_valid, 1'b1);
    btn_raw = 4'b1101;
    wait_slot(0); wait_slot(2);
    rst = 1'b1; #1;
    chk("t6_rst_state", btn_state, 4'h0);
    chk("t6_rst_valid", evt_valid, 1'b0);
    chk("t6_rst_ovf", overflow, 1'b0);
    chk("t6_rst_id", {evt_id, evt_rise}, 3'b000);
    @(posedge clk); #1; rst = 1'b0;
    wait_slot(0); wait_slot(0);
    chk("t6_early", btn_state, 4'h0);
    exp_q.push_back({2'd0, 1'b1});
    wait_slot(0);
    chk("t6_first_btn0", btn_state, 4'b0001);
    chk("t6_valid", evt_valid, 1'b1);
    evt_ready = 1'b1; @(posedge clk); #1; evt_ready = 1'b0;

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
